comp_run_controller: RTL and testbench
======================================

Name: comp_run_controller

Overview:
Run/step/halt sequencer for the integrated single-cycle computer, placed after the program has been written to instruction memory. It holds the computer in reset, releases it, and gates its active-low enable in free-run or single-step mode. Execution stops on a halt PC or a cycle limit. It then dumps a window of data memory as a valid-qualified stream for the display/debug logic.

Parameters:
PC_W, 7, width of computer program counter / instruction address
CYC_W, 16, width of executed-cycle counter and limit
ADDR_W, 7, data memory read address width
DATA_W, 32, data memory word width
RST_CYCLES, 4, cycles computer reset is held low after start
DUMP_WORDS, 5, number of data memory words dumped (addresses 0..DUMP_WORDS-1)

Ports:
clk  in  1  controller and computer clock
reset_sm  in  1  asynchronous, active-low reset
start_n  in  1  active-low pushbutton level; falling edge = start
step_n  in  1  active-low pushbutton level; falling edge = one step
step_mode  in  1  1 = single-step, 0 = free run
halt_addr  in  PC_W  PC value at which execution stops; instruction at halt_addr is not executed
max_cycles  in  CYC_W  executed-cycle limit; 0 = unlimited
pc  in  PC_W  current PC from computer
comp_rst  out  1  active-low computer reset
comp_en  out  1  active-low computer enable (0 = execute this cycle)
dump_rd_addr  out  ADDR_W  data memory read address
dump_rd_data  in  DATA_W  data memory read data, 1-cycle latency
dump_valid  out  1  dump_addr/dump_data valid this cycle
dump_addr  out  ADDR_W  address of dumped word
dump_data  out  DATA_W  dumped word
cycle_count  out  CYC_W  executed cycles since last start
busy  out  1  state is not IDLE or DONE
done  out  1  state is DONE
timeout  out  1  run ended by max_cycles
state  out  3  encoded state for debug

Behaviour:
- States: IDLE=0, RESET_COMP=1, RUN=2, STEP_WAIT=3, STEP_PULSE=4, DUMP=5, DONE=6.
- Reset values (async on reset_sm low, immediate):
  - state IDLE; comp_rst 0; comp_en 1.
  - cycle_count 0, timeout 0, done 0, busy 0, dump_valid 0, dump_rd_addr 0, dump_addr 0, dump_data 0.
  - Button history registers = 1.
- Edge detection:
  - start_evt = prev_start & !start_n; step_evt = prev_step & !step_n.
  - History registers sample the pins every clk.
  - Holding a button low gives exactly one event.
- halt_hit = (pc == halt_addr). timeout_hit = (max_cycles != 0) && (cycle_count >= max_cycles).
- comp_en is combinational:
  - 0 when (state==RUN && !halt_hit && !timeout_hit) or state==STEP_PULSE; else 1.
  - cycle_count increments on every clk edge where comp_en==0 and saturates at all ones.
- comp_rst is registered: 0 in IDLE and RESET_COMP, 1 in all other states.
- IDLE:
  - start_evt -> RESET_COMP.
  - Clear cycle_count, timeout, done; load reset counter.
- RESET_COMP: remain exactly RST_CYCLES cycles, then go to STEP_WAIT if step_mode=1, else RUN.
- RUN (checks in priority order):
  - halt_hit -> DUMP.
  - Else timeout_hit -> DUMP, set timeout=1.
  - Else step_mode=1 -> STEP_WAIT.
  - Halt has priority over timeout when both are true.
- STEP_WAIT (checks in priority order):
  - halt_hit -> DUMP.
  - Else timeout_hit -> DUMP, set timeout.
  - Else step_mode=0 -> RUN.
  - Else step_evt -> STEP_PULSE.
- STEP_PULSE: exactly one cycle, then STEP_WAIT. step_evt in any other state is ignored.
- DUMP:
  - On entry dump_rd_addr=0; it increments each cycle up to DUMP_WORDS-1.
  - One cycle after each address is issued: dump_valid=1, dump_addr = that address, dump_data = dump_rd_data.
  - Occupies DUMP_WORDS+1 cycles; dump_valid is high for exactly DUMP_WORDS consecutive cycles, then DONE.
- DONE:
  - done=1; computer stays out of reset and disabled, so register/memory state is preserved.
  - start_evt -> RESET_COMP with cycle_count, timeout, done cleared.
- start_evt is ignored in RESET_COMP, RUN, STEP_WAIT, STEP_PULSE and DUMP (no restart while busy).
- reset_sm low in any state aborts immediately to reset values; the computer is held in reset from that point.

Test Plan:
- Reset/idle: pulse reset_sm low with buttons released -> comp_rst=0, comp_en=1, state=0, cycle_count=0, busy=0; toggling step_n in IDLE causes no change.
- Free run to halt (computer model: pc+1 per enabled cycle from 0):
  - Setup: halt_addr=27, max_cycles=0, step_mode=0, press start_n.
  - comp_rst low exactly 4 cycles; comp_en low exactly 27 consecutive cycles; cycle_count=27; timeout=0.
  - Dump of memory {7,5,64,16,3} -> dump_valid 5 cycles with addr 0..4, data 7,5,64,16,3; done=1.
- Timeout: halt_addr=100, max_cycles=10 -> comp_en low exactly 10 cycles, cycle_count=10, timeout=1, dump runs, done=1; second start press clears timeout and reruns identically.
- Single step:
  - step_mode=1, three step_n presses, one held low 20 cycles -> comp_en low exactly 1 cycle per press, cycle_count=3, pc=3.
  - Clearing step_mode -> RUN resumes to halt.
- Immediate halt: halt_addr=0 -> zero enabled cycles, cycle_count=0, DUMP entered on first RUN cycle, done=1.
- Abort/ignore:
  - start press during RUN -> no effect.
  - reset_sm low mid-RUN at cycle_count=12 -> same cycle comp_rst=0, comp_en=1, cycle_count=0, state=IDLE.

Source files
------------

// File: rtl/comp_run_controller.sv
// Run/step/halt sequencer for the single-cycle computer: holds it in reset, gates its
// active-low enable in free-run or single-step mode, then streams out a data memory window.
module comp_run_controller #(
    parameter int PC_W       = 7,
    parameter int CYC_W      = 16,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 4,
    parameter int DUMP_WORDS = 5
) (
    input  logic              clk,
    input  logic              reset_sm,
    input  logic              start_n,
    input  logic              step_n,
    input  logic              step_mode,
    input  logic [PC_W-1:0]   halt_addr,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [PC_W-1:0]   pc,
    output logic              comp_rst,
    output logic              comp_en,
    output logic [ADDR_W-1:0] dump_rd_addr,
    input  logic [DATA_W-1:0] dump_rd_data,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int DC_W = $clog2(DUMP_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESET_COMP = 3'd1,
        RUN        = 3'd2,
        STEP_WAIT  = 3'd3,
        STEP_PULSE = 3'd4,
        DUMP       = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              prev_start, prev_step;
    logic [RC_W-1:0]   rst_cnt;
    logic [DC_W-1:0]   dump_cnt;
    logic              start_evt, step_evt, halt_hit, timeout_hit;
    logic              clear_run, set_timeout;

    assign start_evt   = prev_start & ~start_n;
    assign step_evt    = prev_step & ~step_n;
    assign halt_hit    = (pc == halt_addr);
    assign timeout_hit = (max_cycles != '0) && (cycle_count >= max_cycles);

    always_comb begin
        state_d     = state_q;
        clear_run   = 1'b0;
        set_timeout = 1'b0;
        comp_en     = 1'b1;
        case (state_q)
            IDLE, DONE: begin
                if (start_evt) begin
                    state_d   = RESET_COMP;
                    clear_run = 1'b1;
                end
            end
            RESET_COMP: begin
                if (rst_cnt == RC_W'(RST_CYCLES - 1))
                    state_d = step_mode ? STEP_WAIT : RUN;
            end
            RUN: begin
                if (!halt_hit && !timeout_hit)
                    comp_en = 1'b0;
                if (halt_hit)
                    state_d = DUMP;
                else if (timeout_hit) begin
                    state_d     = DUMP;
                    set_timeout = 1'b1;
                end else if (step_mode)
                    state_d = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (halt_hit)
                    state_d = DUMP;
                else if (timeout_hit) begin
                    state_d     = DUMP;
                    set_timeout = 1'b1;
                end else if (!step_mode)
                    state_d = RUN;
                else if (step_evt)
                    state_d = STEP_PULSE;
            end
            STEP_PULSE: begin
                comp_en = 1'b0;
                state_d = STEP_WAIT;
            end
            DUMP: begin
                if (dump_cnt == DC_W'(DUMP_WORDS))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sm) begin
        if (!reset_sm) begin
            state_q      <= IDLE;
            prev_start   <= 1'b1;
            prev_step    <= 1'b1;
            comp_rst     <= 1'b0;
            cycle_count  <= '0;
            timeout      <= 1'b0;
            rst_cnt      <= '0;
            dump_cnt     <= '0;
            dump_rd_addr <= '0;
            dump_valid   <= 1'b0;
            dump_addr    <= '0;
        end else begin
            state_q    <= state_d;
            prev_start <= start_n;
            prev_step  <= step_n;
            comp_rst   <= !(state_d == IDLE || state_d == RESET_COMP);
            if (clear_run) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
                rst_cnt     <= '0;
            end else begin
                if (!comp_en && cycle_count != '1)
                    cycle_count <= cycle_count + CYC_W'(1);
                if (set_timeout)
                    timeout <= 1'b1;
                if (state_q == RESET_COMP)
                    rst_cnt <= rst_cnt + RC_W'(1);
            end
            if (state_d == DUMP && state_q != DUMP) begin
                dump_cnt     <= '0;
                dump_rd_addr <= '0;
            end else if (state_q == DUMP) begin
                dump_cnt <= dump_cnt + DC_W'(1);
                if (dump_rd_addr != ADDR_W'(DUMP_WORDS - 1))
                    dump_rd_addr <= dump_rd_addr + ADDR_W'(1);
            end
            // valid/addr trail the issued address by one cycle to line up with the memory latency
            dump_valid <= (state_q == DUMP) && (dump_cnt < DC_W'(DUMP_WORDS));
            dump_addr  <= dump_rd_addr;
        end
    end

    assign dump_data = dump_valid ? dump_rd_data : '0;
    assign done      = (state_q == DONE);
    assign busy      = !(state_q == IDLE || state_q == DONE);
    assign state     = state_q;

endmodule

// File: tb/tb_comp_run_controller.sv
// Self-checking bench for comp_run_controller with a pc+1 computer model and a
// registered-read data memory model; dump words are checked through a scoreboard queue.
module tb_comp_run_controller;

    logic        clk = 1'b0;
    logic        reset_sm = 1'b0;
    logic        start_n = 1'b1;
    logic        step_n = 1'b1;
    logic        step_mode = 1'b0;
    logic [6:0]  halt_addr = '0;
    logic [15:0] max_cycles = '0;
    logic [6:0]  pc;
    logic        comp_rst, comp_en;
    logic [6:0]  dump_rd_addr, dump_addr;
    logic [31:0] dump_rd_data, dump_data;
    logic        dump_valid, busy, done, timeout;
    logic [15:0] cycle_count;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    int en_total, en_run, en_max, en_seg, rst_low;

    typedef struct {
        logic [6:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:127];

    comp_run_controller #(
        .PC_W(7), .CYC_W(16), .ADDR_W(7), .DATA_W(32), .RST_CYCLES(4), .DUMP_WORDS(5)
    ) dut (
        .clk(clk), .reset_sm(reset_sm), .start_n(start_n), .step_n(step_n),
        .step_mode(step_mode), .halt_addr(halt_addr), .max_cycles(max_cycles), .pc(pc),
        .comp_rst(comp_rst), .comp_en(comp_en), .dump_rd_addr(dump_rd_addr),
        .dump_rd_data(dump_rd_data), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .cycle_count(cycle_count), .busy(busy), .done(done),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!comp_rst) pc <= '0;
        else if (!comp_en) pc <= pc + 7'd1;
        dump_rd_data <= mem[dump_rd_addr];
    end

    always @(negedge clk) begin
        if (!comp_en) begin
            en_total = en_total + 1;
            en_run = en_run + 1;
            if (en_run == 1) en_seg = en_seg + 1;
            if (en_run > en_max) en_max = en_run;
        end else begin
            en_run = 0;
        end
        if (busy && !comp_rst) rst_low = rst_low + 1;
        if (dump_valid) begin
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL dump_extra: addr=%0d data=%0d, required no valid word", dump_addr, dump_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dump_addr !== e.a || dump_data !== e.d) begin
                    n_bad = n_bad + 1;
                    $display("FAIL dump_word: addr=%0d data=%0d, required addr=%0d data=%0d",
                             dump_addr, dump_data, e.a, e.d);
                end
            end
        end
    end

    task automatic clear_counts();
        @(posedge clk);
        #2;
        en_total = 0; en_run = 0; en_max = 0; en_seg = 0; rst_low = 0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.a = 7'(i);
            e.d = mem[i];
            sb.push_back(e);
        end
    endtask

    task automatic press_start(input int hold);
        @(negedge clk);
        start_n = 1'b0;
        repeat (hold) @(negedge clk);
        start_n = 1'b1;
    endtask

    task automatic press_step(input int hold);
        @(negedge clk);
        step_n = 1'b0;
        repeat (hold) @(negedge clk);
        step_n = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        n_cmp = n_cmp + 1;
        if (done !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL wait_done: done=%b, required 1 within budget", done);
        end
    endtask

    task automatic check_end(input string tag, input int exp_en, input int exp_cc, input logic exp_to);
        n_cmp = n_cmp + 6;
        if (en_total != exp_en) begin
            n_bad++; $display("FAIL %s_en_cycles: got %0d, required %0d", tag, en_total, exp_en);
        end
        if (cycle_count !== 16'(exp_cc)) begin
            n_bad++; $display("FAIL %s_cycle_count: got %0d, required %0d", tag, cycle_count, exp_cc);
        end
        if (timeout !== exp_to) begin
            n_bad++; $display("FAIL %s_timeout: got %b, required %b", tag, timeout, exp_to);
        end
        if (state !== 3'd6 || busy !== 1'b0 || comp_rst !== 1'b1 || comp_en !== 1'b1) begin
            n_bad++; $display("FAIL %s_done_state: state=%0d busy=%b rst=%b en=%b, required 6 0 1 1",
                              tag, state, busy, comp_rst, comp_en);
        end
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL %s_dump_missing: %0d words not seen, required 0", tag, sb.size());
        end
        if (exp_en > 0 && en_seg != 1 && tag != "step") begin
            n_bad++; $display("FAIL %s_en_segments: got %0d, required 1", tag, en_seg);
        end
    endtask

    task automatic test_reset();
        reset_sm = 1'b0;
        #3;
        n_cmp = n_cmp + 1;
        if (comp_rst !== 1'b0 || comp_en !== 1'b1 || state !== 3'd0 || cycle_count !== 16'd0 ||
            busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || dump_valid !== 1'b0 ||
            dump_rd_addr !== 7'd0 || dump_addr !== 7'd0 || dump_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: rst=%b en=%b state=%0d cc=%0d busy=%b done=%b to=%b dv=%b",
                     comp_rst, comp_en, state, cycle_count, busy, done, timeout, dump_valid);
        end
        repeat (3) @(negedge clk);
        reset_sm = 1'b1;
        clear_counts();
        press_step(1);
        press_step(3);
        repeat (4) @(negedge clk);
        n_cmp = n_cmp + 1;
        if (state !== 3'd0 || en_total != 0 || comp_rst !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_step_ignored: state=%0d en_cycles=%0d rst=%b busy=%b, required 0 0 0 0",
                     state, en_total, comp_rst, busy);
        end
    endtask

    task automatic test_free_run();
        mem[0] = 32'd7; mem[1] = 32'd5; mem[2] = 32'd64; mem[3] = 32'd16; mem[4] = 32'd3;
        halt_addr = 7'd27; max_cycles = 16'd0; step_mode = 1'b0;
        clear_counts();
        push_dump();
        press_start(2);
        wait_done();
        n_cmp = n_cmp + 2;
        if (rst_low != 4) begin
            n_bad++; $display("FAIL free_rst_cycles: got %0d, required 4", rst_low);
        end
        if (en_max != 27) begin
            n_bad++; $display("FAIL free_en_consecutive: got %0d, required 27", en_max);
        end
        check_end("free", 27, 27, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) mem[i] = $urandom;
        halt_addr = 7'd100; max_cycles = 16'd10; step_mode = 1'b0;
        for (int r = 0; r < 2; r++) begin
            clear_counts();
            push_dump();
            press_start(3);
            n_cmp = n_cmp + 1;
            if (timeout !== 1'b0 || cycle_count !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL timeout_restart_clear: to=%b cc=%0d done=%b busy=%b, required 0 0 0 1",
                         timeout, cycle_count, done, busy);
            end
            wait_done();
            check_end("timeout", 10, 10, 1'b1);
        end
    endtask

    task automatic test_single_step();
        for (int i = 0; i < 5; i++) mem[i] = $urandom;
        halt_addr = 7'd10; max_cycles = 16'd0; step_mode = 1'b1;
        clear_counts();
        push_dump();
        press_start(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (comp_rst === 1'b1) break;
        end
        repeat (3) @(negedge clk);
        n_cmp = n_cmp + 1;
        if (en_total != 0 || state !== 3'd3) begin
            n_bad++; $display("FAIL step_wait_idle: en_cycles=%0d state=%0d, required 0 3", en_total, state);
        end
        press_step(2);
        repeat (3) @(negedge clk);
        press_step(20);
        repeat (3) @(negedge clk);
        press_step(1);
        repeat (3) @(negedge clk);
        n_cmp = n_cmp + 1;
        if (en_total != 3 || en_max != 1 || cycle_count !== 16'd3 || pc !== 7'd3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL step_count: en=%0d max=%0d cc=%0d pc=%0d busy=%b, required 3 1 3 3 1",
                     en_total, en_max, cycle_count, pc, busy);
        end
        step_mode = 1'b0;
        wait_done();
        check_end("step", 10, 10, 1'b0);
    endtask

    task automatic test_immediate_halt();
        for (int i = 0; i < 5; i++) mem[i] = $urandom;
        halt_addr = 7'd0; max_cycles = 16'd0; step_mode = 1'b0;
        clear_counts();
        push_dump();
        press_start(2);
        wait_done();
        check_end("imm_halt", 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        halt_addr = 7'd100; max_cycles = 16'd0; step_mode = 1'b0;
        clear_counts();
        press_start(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cycle_count >= 16'd3) break;
        end
        press_start(2);
        repeat (2) @(negedge clk);
        n_cmp = n_cmp + 1;
        if (state !== 3'd2 || comp_rst !== 1'b1 || comp_en !== 1'b0) begin
            n_bad++;
            $display("FAIL start_ignored_run: state=%0d rst=%b en=%b, required 2 1 0", state, comp_rst, comp_en);
        end
        for (int i = 0; i < 40; i++) begin
            if (cycle_count === 16'd12) break;
            @(negedge clk);
        end
        n_cmp = n_cmp + 1;
        if (cycle_count !== 16'd12) begin
            n_bad++; $display("FAIL abort_reach_12: got %0d, required 12", cycle_count);
        end
        reset_sm = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if (comp_rst !== 1'b0 || comp_en !== 1'b1 || cycle_count !== 16'd0 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL abort_reset: rst=%b en=%b cc=%0d state=%0d, required 0 1 0 0",
                     comp_rst, comp_en, cycle_count, state);
        end
        repeat (2) @(negedge clk);
        reset_sm = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3 + 1);
        en_total = 0; en_run = 0; en_max = 0; en_seg = 0; rst_low = 0;
        test_reset();
        test_free_run();
        test_timeout();
        test_single_step();
        test_immediate_halt();
        test_abort();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
